bmp_crop_scale: RTL and testbench

Parametrised crop-and-decimate engine for bottom-up BMP images in byte-addressed memory. It is the next generation of the fixed 24-bit crop unit: pixel size, source geometry, header size and read latency are parameters, and a power-of-two decimation factor is added. Output rows are written in BMP file order with 4-byte row padding. An invalid window is flagged instead of being processed. It sits between the source frame buffer and the output BMP buffer, ahead of the header writer, which takes `outW`/`outH` from this block.

---
 rtl/bmp_crop_scale_if.sv | 23 ++
 rtl/bmp_crop_scale.sv | 219 +++++++++++++++++++++
 tb/tb_bmp_crop_scale.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bmp_crop_scale_if.sv
// Memory-side bus of the crop/decimate engine: a read port towards the
// source frame buffer and a write port towards the output BMP buffer.
interface bmp_crop_scale_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] readAddr;
    logic              rden;
    logic [DATA_W-1:0] readdata;
    logic [ADDR_W-1:0] writeAddr;
    logic [DATA_W-1:0] wrdata;
    logic              wren;

    modport master (
        output readAddr, rden, writeAddr, wrdata, wren,
        input  readdata
    );

    modport slave (
        input  readAddr, rden, writeAddr, wrdata, wren,
        output readdata
    );
endinterface

// File: rtl/bmp_crop_scale.sv
// Crop-and-decimate engine for bottom-up BMP pixel arrays. Reads the
// requested window byte by byte, keeps every s-th pixel in both directions,
// and writes the result in BMP file order with 4-byte row padding.
module bmp_crop_scale #(
    parameter int WIDTH     = 100,
    parameter int HEIGHT    = 100,
    parameter int BPP       = 3,
    parameter int HDR_BYTES = 54,
    parameter int RD_LAT    = 1,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             done,
    output logic             busy,
    output logic             err,
    input  logic [10:0]      xMin,
    input  logic [10:0]      xMax,
    input  logic [10:0]      yMin,
    input  logic [10:0]      yMax,
    input  logic [1:0]       scaleLog2,
    bmp_crop_scale_if.master mem,
    output logic [10:0]      outW,
    output logic [10:0]      outH
);
    localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(((WIDTH * BPP + 3) / 4) * 4);
    localparam logic [ADDR_W-1:0] HDR       = ADDR_W'(HDR_BYTES);
    localparam logic [ADDR_W-1:0] BPP_A     = ADDR_W'(BPP);
    localparam logic [ADDR_W-1:0] HM1       = ADDR_W'(HEIGHT - 1);
    localparam logic [31:0]       W_LIM     = 32'(WIDTH);
    localparam logic [31:0]       H_LIM     = 32'(HEIGHT);
    localparam logic [1:0]        LAST_C    = 2'(BPP - 1);
    localparam int                WCW       = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
    localparam logic [WCW-1:0]    WAIT_INIT = WCW'((RD_LAT > 1) ? RD_LAT - 2 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_READ, S_WAIT, S_WRITE, S_PAD, S_DONE
    } state_t;

    state_t            state, state_n;
    logic [10:0]       xmin_q, xmax_q, ymin_q, ymax_q;
    logic [10:0]       xmin_n, xmax_n, ymin_n, ymax_n;
    logic [1:0]        sl_q, sl_n;
    logic [10:0]       x_q, y_q, x_n, y_n;
    logic [1:0]        c_q, c_n;
    logic [WCW-1:0]    wcnt_q, wcnt_n;
    logic [1:0]        pcnt_q, pcnt_n, pad_q, pad_n;
    logic [10:0]       ow_q, oh_q, ow_n, oh_n;
    logic              err_q, err_n;
    logic [ADDR_W-1:0] raddr_q, waddr_q, waddr_n;
    logic [10:0]       dx, dy;
    logic [11:0]       s;
    logic              row_end;

    function automatic logic [ADDR_W-1:0] src_addr(input logic [10:0] yy,
                                                   input logic [10:0] xx,
                                                   input logic [1:0]  cc);
        src_addr = HDR + (HM1 - ADDR_W'(yy)) * STRIDE + ADDR_W'(xx) * BPP_A + ADDR_W'(cc);
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // Next-state logic plus next values of the window walk.
    always_comb begin
        state_n = state;
        xmin_n  = xmin_q;
        xmax_n  = xmax_q;
        ymin_n  = ymin_q;
        ymax_n  = ymax_q;
        sl_n    = sl_q;
        x_n     = x_q;
        y_n     = y_q;
        c_n     = c_q;
        wcnt_n  = wcnt_q;
        pcnt_n  = pcnt_q;
        pad_n   = pad_q;
        ow_n    = ow_q;
        oh_n    = oh_q;
        err_n   = err_q;
        waddr_n = waddr_q;
        row_end = 1'b0;
        s       = 12'd1 << sl_q;
        dx      = xmax_q - xmin_q;
        dy      = ymax_q - ymin_q;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    xmin_n  = xMin;
                    xmax_n  = xMax;
                    ymin_n  = yMin;
                    ymax_n  = yMax;
                    sl_n    = scaleLog2;
                    state_n = S_SETUP;
                end
            end
            S_SETUP: begin
                if (!(xmin_q <= xmax_q && 32'(xmax_q) < W_LIM &&
                      ymin_q <= ymax_q && 32'(ymax_q) < H_LIM)) begin
                    err_n   = 1'b1;
                    ow_n    = '0;
                    oh_n    = '0;
                    state_n = S_DONE;
                end else begin
                    err_n   = 1'b0;
                    ow_n    = (dx >> sl_q) + 11'd1;
                    oh_n    = (dy >> sl_q) + 11'd1;
                    pad_n   = 2'd0 - 2'(ow_n[1:0] * 2'(BPP));
                    // Topmost sampled row is the last one in file order.
                    y_n     = ymin_q + ((dy >> sl_q) << sl_q);
                    x_n     = xmin_q;
                    c_n     = '0;
                    waddr_n = HDR;
                    state_n = S_READ;
                end
            end
            S_READ: begin
                wcnt_n  = WAIT_INIT;
                state_n = (RD_LAT > 1) ? S_WAIT : S_WRITE;
            end
            S_WAIT: begin
                if (wcnt_q == '0) state_n = S_WRITE;
                else              wcnt_n  = wcnt_q - WCW'(1);
            end
            S_WRITE: begin
                waddr_n = waddr_q + ADDR_W'(1);
                if (c_q != LAST_C) begin
                    c_n     = c_q + 2'd1;
                    state_n = S_READ;
                end else if ({1'b0, x_q} + s <= {1'b0, xmax_q}) begin
                    x_n     = x_q + s[10:0];
                    c_n     = '0;
                    state_n = S_READ;
                end else if (pad_q != '0) begin
                    pcnt_n  = pad_q - 2'd1;
                    state_n = S_PAD;
                end else begin
                    row_end = 1'b1;
                end
            end
            S_PAD: begin
                waddr_n = waddr_q + ADDR_W'(1);
                if (pcnt_q == '0) row_end = 1'b1;
                else              pcnt_n  = pcnt_q - 2'd1;
            end
            default: state_n = S_IDLE;
        endcase
        if (row_end) begin
            if (y_q > ymin_q) begin
                y_n     = y_q - s[10:0];
                x_n     = xmin_q;
                c_n     = '0;
                state_n = S_READ;
            end else begin
                state_n = S_DONE;
            end
        end
    end

    // Datapath registers; the read address is computed ahead of each READ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymin_q  <= '0;
            ymax_q  <= '0;
            sl_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            c_q     <= '0;
            wcnt_q  <= '0;
            pcnt_q  <= '0;
            pad_q   <= '0;
            ow_q    <= '0;
            oh_q    <= '0;
            err_q   <= 1'b0;
            raddr_q <= '0;
            waddr_q <= HDR;
        end else begin
            xmin_q  <= xmin_n;
            xmax_q  <= xmax_n;
            ymin_q  <= ymin_n;
            ymax_q  <= ymax_n;
            sl_q    <= sl_n;
            x_q     <= x_n;
            y_q     <= y_n;
            c_q     <= c_n;
            wcnt_q  <= wcnt_n;
            pcnt_q  <= pcnt_n;
            pad_q   <= pad_n;
            ow_q    <= ow_n;
            oh_q    <= oh_n;
            err_q   <= err_n;
            waddr_q <= waddr_n;
            if (state_n == S_READ) raddr_q <= src_addr(y_n, x_n, c_n);
        end
    end

    assign busy          = state inside {S_SETUP, S_READ, S_WAIT, S_WRITE, S_PAD};
    assign done          = (state == S_DONE);
    assign err           = err_q;
    assign outW          = done ? ow_q : '0;
    assign outH          = done ? oh_q : '0;
    assign mem.readAddr  = raddr_q;
    assign mem.writeAddr = waddr_q;
    assign mem.rden      = (state == S_READ);
    assign mem.wren      = (state == S_WRITE) || (state == S_PAD);
    assign mem.wrdata    = (state == S_WRITE) ? DATA_W'(mem.readdata[7:0]) : '0;

    if (DATA_W > 8) begin : g_rd_hi
        logic unused_rd_hi;
        assign unused_rd_hi = ^mem.readdata[DATA_W-1:8];
    end
endmodule

// File: tb/tb_bmp_crop_scale.sv
// Bench for bmp_crop_scale: two instances (read latency 1 and 3) share the
// control inputs and see the same 4x4, 3-byte-per-pixel source image. A
// window-walk model lists every expected read and write; a negedge process
// checks each strobe against it.
`timescale 1ns/1ps
module tb_bmp_crop_scale;
    localparam int W      = 4;
    localparam int H      = 4;
    localparam int BPP    = 3;
    localparam int HDR    = 54;
    localparam int STRIDE = ((W * BPP + 3) / 4) * 4;
    localparam int BUDGET = 400;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [10:0] xMin = '0, xMax = '0, yMin = '0, yMax = '0;
    logic [1:0]  scaleLog2 = '0;
    logic        done_a, busy_a, err_a, done_b, busy_b, err_b;
    logic [10:0] outW_a, outH_a, outW_b, outH_b;

    bmp_crop_scale_if #(.ADDR_W(32), .DATA_W(16)) bus_a ();
    bmp_crop_scale_if #(.ADDR_W(32), .DATA_W(16)) bus_b ();

    bmp_crop_scale #(.WIDTH(W), .HEIGHT(H), .BPP(BPP), .HDR_BYTES(HDR),
                     .RD_LAT(1), .ADDR_W(32), .DATA_W(16)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .start(start), .done(done_a), .busy(busy_a),
        .err(err_a), .xMin(xMin), .xMax(xMax), .yMin(yMin), .yMax(yMax),
        .scaleLog2(scaleLog2), .mem(bus_a), .outW(outW_a), .outH(outH_a)
    );

    bmp_crop_scale #(.WIDTH(W), .HEIGHT(H), .BPP(BPP), .HDR_BYTES(HDR),
                     .RD_LAT(3), .ADDR_W(32), .DATA_W(16)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .start(start), .done(done_b), .busy(busy_b),
        .err(err_b), .xMin(xMin), .xMax(xMax), .yMin(yMin), .yMax(yMax),
        .scaleLog2(scaleLog2), .mem(bus_b), .outW(outW_b), .outH(outH_b)
    );

    always #5 clk = ~clk;

    // Source memory with 1- and 3-cycle read pipelines; unrequested cycles return junk.
    logic [7:0]  mem [0:255];
    logic [15:0] junk = 16'hA5C3;
    logic [31:0] pa = '0;
    logic        va = 1'b0;
    logic [31:0] pb [0:2] = '{32'd0, 32'd0, 32'd0};
    logic        vb [0:2] = '{1'b0, 1'b0, 1'b0};

    always @(posedge clk) begin
        junk  <= 16'($urandom) | 16'h0100;
        pa    <= bus_a.readAddr;
        va    <= bus_a.rden;
        pb[0] <= bus_b.readAddr;
        vb[0] <= bus_b.rden;
        pb[1] <= pb[0];
        vb[1] <= vb[0];
        pb[2] <= pb[1];
        vb[2] <= vb[1];
    end

    always_comb begin
        bus_a.readdata = {junk[15:8], va    ? mem[pa[7:0]]    : junk[7:0]};
        bus_b.readdata = {junk[15:8], vb[2] ? mem[pb[2][7:0]] : junk[7:0]};
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    task automatic miss(input string nm, input logic [63:0] act);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got %0d, expected no such event", nm, act);
    endtask

    // Expected transaction lists.
    int         exp_ra [0:63];
    int         exp_wa [0:63];
    logic [7:0] exp_wd [0:63];
    int         exp_nr, exp_nw, exp_ow, exp_oh, exp_pad;
    bit         exp_err;
    int         rd_idx [0:1];
    int         wr_idx [0:1];

    task automatic build_model(input int xmn, input int xmx, input int ymn,
                               input int ymx, input int sl);
        int s, y, x, a;
        exp_nr = 0;
        exp_nw = 0;
        exp_err = !(xmn <= xmx && xmx < W && ymn <= ymx && ymx < H);
        if (exp_err) begin
            exp_ow = 0;
            exp_oh = 0;
            exp_pad = 0;
            return;
        end
        s       = 2 ** sl;
        exp_ow  = (xmx - xmn) / s + 1;
        exp_oh  = (ymx - ymn) / s + 1;
        exp_pad = (4 - (exp_ow * BPP) % 4) % 4;
        for (int r = 0; r < exp_oh; r++) begin
            y = ymn + (exp_oh - 1 - r) * s;
            for (int i = 0; i < exp_ow; i++) begin
                x = xmn + i * s;
                for (int c = 0; c < BPP; c++) begin
                    a = HDR + (H - 1 - y) * STRIDE + x * BPP + c;
                    exp_ra[exp_nr] = a;
                    exp_nr++;
                    exp_wa[exp_nw] = HDR + exp_nw;
                    exp_wd[exp_nw] = mem[a];
                    exp_nw++;
                end
            end
            for (int p = 0; p < exp_pad; p++) begin
                exp_wa[exp_nw] = HDR + exp_nw;
                exp_wd[exp_nw] = 8'h00;
                exp_nw++;
            end
        end
    endtask

    function automatic int exp_cycles(input int lat);
        if (exp_err) return 1;
        return 1 + exp_ow * exp_oh * BPP * (lat + 1) + exp_oh * exp_pad;
    endfunction

    task automatic check_bus(input int k, input logic rden, input logic [31:0] ra,
                             input logic wren, input logic [31:0] wa, input logic [15:0] wd);
        if (rden && wren) miss($sformatf("strobe_overlap_%0d", k), 1);
        if (rden) begin
            if (rd_idx[k] < exp_nr)
                chk($sformatf("readAddr_%0d[%0d]", k, rd_idx[k]), ra, exp_ra[rd_idx[k]]);
            else
                miss($sformatf("extra_read_%0d", k), ra);
            rd_idx[k]++;
        end
        if (wren) begin
            if (wr_idx[k] < exp_nw) begin
                chk($sformatf("writeAddr_%0d[%0d]", k, wr_idx[k]), wa, exp_wa[wr_idx[k]]);
                chk($sformatf("wrdata_%0d[%0d]", k, wr_idx[k]), wd, {8'h00, exp_wd[wr_idx[k]]});
            end else begin
                miss($sformatf("extra_write_%0d", k), wa);
            end
            wr_idx[k]++;
        end
    endtask

    // Per-cycle bus compare for both instances.
    always @(negedge clk) begin
        if (rst_n) begin
            check_bus(0, bus_a.rden, bus_a.readAddr, bus_a.wren, bus_a.writeAddr, bus_a.wrdata);
            check_bus(1, bus_b.rden, bus_b.readAddr, bus_b.wren, bus_b.writeAddr, bus_b.wrdata);
        end
    end

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    endtask

    task automatic pulse_start(input int xmn, input int xmx, input int ymn,
                               input int ymx, input int sl);
        build_model(xmn, xmx, ymn, ymx, sl);
        rd_idx[0] = 0;
        rd_idx[1] = 0;
        wr_idx[0] = 0;
        wr_idx[1] = 0;
        @(negedge clk);
        xMin      = 11'(xmn);
        xMax      = 11'(xmx);
        yMin      = 11'(ymn);
        yMax      = 11'(ymx);
        scaleLog2 = 2'(sl);
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start_a", busy_a, 1);
        chk("done_after_start_a", done_a, 0);
        chk("busy_after_start_b", busy_b, 1);
        chk("done_after_start_b", done_b, 0);
    endtask

    // One job on both instances; optionally pokes start with other inputs mid-run.
    task automatic run(input int xmn, input int xmx, input int ymn,
                       input int ymx, input int sl, input bit poke);
        int lat_a, lat_b;
        pulse_start(xmn, xmx, ymn, ymx, sl);
        lat_a = -1;
        lat_b = -1;
        for (int cyc = 1; cyc <= BUDGET && (lat_a < 0 || lat_b < 0); cyc++) begin
            @(negedge clk);
            if (poke && cyc == 10) begin
                start     = 1'b1;
                xMin      = 11'd1;
                xMax      = 11'd1;
                yMin      = 11'd0;
                yMax      = 11'd0;
                scaleLog2 = 2'd3;
            end else begin
                start = 1'b0;
            end
            if (lat_a < 0 && done_a) lat_a = cyc;
            if (lat_b < 0 && done_b) lat_b = cyc;
        end
        start = 1'b0;
        if (lat_a < 0) miss("timeout_a", 0);
        else           chk("latency_a", lat_a, exp_cycles(1));
        if (lat_b < 0) miss("timeout_b", 0);
        else           chk("latency_b", lat_b, exp_cycles(3));
        chk("err_a", err_a, exp_err);
        chk("err_b", err_b, exp_err);
        chk("busy_end_a", busy_a, 0);
        chk("busy_end_b", busy_b, 0);
        chk("outW_a", outW_a, exp_ow);
        chk("outH_a", outH_a, exp_oh);
        chk("outW_b", outW_b, exp_ow);
        chk("outH_b", outH_b, exp_oh);
        chk("reads_a", rd_idx[0], exp_nr);
        chk("writes_a", wr_idx[0], exp_nw);
        chk("reads_b", rd_idx[1], exp_nr);
        chk("writes_b", wr_idx[1], exp_nw);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_done_a"}, done_a, 0);
        chk({tag, "_busy_a"}, busy_a, 0);
        chk({tag, "_err_a"}, err_a, 0);
        chk({tag, "_rden_a"}, bus_a.rden, 0);
        chk({tag, "_wren_a"}, bus_a.wren, 0);
        chk({tag, "_wrdata_a"}, bus_a.wrdata, 0);
        chk({tag, "_readAddr_a"}, bus_a.readAddr, 0);
        chk({tag, "_writeAddr_a"}, bus_a.writeAddr, HDR);
        chk({tag, "_outW_a"}, outW_a, 0);
        chk({tag, "_outH_a"}, outH_a, 0);
        chk({tag, "_done_b"}, done_b, 0);
        chk({tag, "_busy_b"}, busy_b, 0);
        chk({tag, "_rden_b"}, bus_b.rden, 0);
        chk({tag, "_wren_b"}, bus_b.wren, 0);
        chk({tag, "_readAddr_b"}, bus_b.readAddr, 0);
        chk({tag, "_writeAddr_b"}, bus_b.writeAddr, HDR);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        fill_mem();
        exp_nr = 0;
        exp_nw = 0;
        rd_idx[0] = 0;
        rd_idx[1] = 0;
        wr_idx[0] = 0;
        wr_idx[1] = 0;
        @(negedge clk);
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Full window: 48 bytes, no padding.
        run(0, 3, 0, 3, 0, 1'b0);
        chk("model_full_writes", exp_nw, 48);
        chk("model_full_cycles_l1", exp_cycles(1), 97);
        chk("model_full_cycles_l3", exp_cycles(3), 193);
        chk("model_full_first_read", exp_ra[0], HDR);

        // Sub-window: two rows of 6 data + 2 pad bytes, source row 2 first.
        run(1, 2, 1, 2, 0, 1'b0);
        chk("model_sub_first_read", exp_ra[0], 69);
        chk("model_sub_writes", exp_nw, 16);
        chk("model_sub_pad", exp_pad, 2);

        // Decimation by 2: pixels x=0,2 of rows y=2 then y=0.
        run(0, 3, 0, 3, 1, 1'b0);
        chk("model_dec_ow", exp_ow, 2);
        chk("model_dec_read0", exp_ra[0], 66);
        chk("model_dec_read3", exp_ra[3], 72);
        chk("model_dec_read6", exp_ra[6], 90);

        // Invalid windows, then a valid job (with a stray start) clears err.
        run(3, 1, 0, 3, 0, 1'b0);
        run(0, 4, 0, 3, 0, 1'b0);
        run(0, 3, 2, 4, 0, 1'b0);
        run(0, 3, 0, 3, 0, 1'b1);

        // Asynchronous reset in the middle of a row, then a clean restart.
        fill_mem();
        pulse_start(0, 3, 0, 3, 0);
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_values("midrow");
        @(negedge clk);
        rst_n = 1'b1;
        run(0, 3, 0, 3, 0, 1'b0);

        // Random windows, some of them out of range.
        for (int n = 0; n < 14; n++) begin
            fill_mem();
            run($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3),
                $urandom_range(0, 4), $urandom_range(0, 3), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
